// File: rtl/mlp_stream_driver_if.sv
// Host-side bundle of the MLP stream driver: sample stream in, weight writes, result stream out.
interface mlp_stream_driver_if;
  logic               s_valid;
  logic               s_ready;
  logic [19:0]        s_x;
  logic               w_we;
  logic [4:0]         w_addr;
  logic signed [4:0]  w_data;
  logic               w_busy;
  logic               m_valid;
  logic               m_ready;
  logic signed [16:0] m_out0;
  logic signed [16:0] m_out1;

  modport master (
    output s_valid, s_x, w_we, w_addr, w_data, m_ready,
    input  s_ready, w_busy, m_valid, m_out0, m_out1
  );

  modport slave (
    input  s_valid, s_x, w_we, w_addr, w_data, m_ready,
    output s_ready, w_busy, m_valid, m_out0, m_out1
  );
endinterface

// File: rtl/mlp_stream_driver.sv
// Feeds the 4-4-2 MLP core from a sample FIFO and collects its result pairs into a result FIFO.
// in_ready -> m_valid is 4 cycles; issue is credit-limited so a captured result never overflows the result FIFO.
module mlp_stream_driver #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mlp_stream_driver_if.slave bus,
  output logic signed [4:0]  x0, x1, x2, x3,
  output logic signed [4:0]  w04, w05, w06, w07, w14, w15, w16, w17,
  output logic signed [4:0]  w24, w25, w26, w27, w34, w35, w36, w37,
  output logic signed [4:0]  w48, w49, w58, w59, w68, w69, w78, w79,
  output logic               in_ready,
  input  logic signed [16:0] out0,
  input  logic signed [16:0] out1,
  input  logic               out0_ready,
  input  logic               out1_ready,
  output logic [1:0]         err
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  typedef enum logic {ST_FLUSH, ST_RUN} state_t;

  state_t            state_q;
  logic [1:0]        flush_cnt_q;
  logic [19:0]       in_mem_q [IN_DEPTH];
  logic [IAW-1:0]    in_wr_q, in_rd_q;
  logic [IAW:0]      in_cnt_q;
  logic [33:0]       out_mem_q [OUT_DEPTH];
  logic [OAW-1:0]    out_wr_q, out_rd_q;
  logic [OAW:0]      out_cnt_q;
  logic [2:0]        in_flight_q;
  logic              in_ready_q;
  logic [19:0]       x_q;
  logic signed [4:0] w_q [24];
  logic              out0_prev_q;
  logic [1:0]        err_q;

  logic run, w_acc, s_push, issue, cap, m_pop, credit_ok;

  assign run        = (state_q == ST_RUN);
  assign bus.w_busy = !run || (in_flight_q != 3'd0) || in_ready_q;
  assign w_acc      = bus.w_we && !bus.w_busy;
  assign bus.s_ready = run && (int'(in_cnt_q) != IN_DEPTH);
  assign s_push     = bus.s_valid && bus.s_ready;
  // Results already promised to the core count against result FIFO space.
  assign credit_ok  = (int'(in_flight_q) + int'(out_cnt_q) + int'(in_ready_q)) < OUT_DEPTH;
  assign issue      = run && (in_cnt_q != '0) && credit_ok && !w_acc;
  assign cap        = run && out0_ready && (in_flight_q != 3'd0);
  assign bus.m_valid = (out_cnt_q != '0);
  assign m_pop      = bus.m_valid && bus.m_ready;
  assign {bus.m_out1, bus.m_out0} = out_mem_q[out_rd_q];

  assign in_ready = in_ready_q;
  assign err      = err_q;
  assign {x3, x2, x1, x0} = x_q;
  assign {w04, w05, w06, w07} = {w_q[0],  w_q[1],  w_q[2],  w_q[3]};
  assign {w14, w15, w16, w17} = {w_q[4],  w_q[5],  w_q[6],  w_q[7]};
  assign {w24, w25, w26, w27} = {w_q[8],  w_q[9],  w_q[10], w_q[11]};
  assign {w34, w35, w36, w37} = {w_q[12], w_q[13], w_q[14], w_q[15]};
  assign {w48, w49, w58, w59} = {w_q[16], w_q[17], w_q[18], w_q[19]};
  assign {w68, w69, w78, w79} = {w_q[20], w_q[21], w_q[22], w_q[23]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= 2'd3;
      for (int i = 0; i < IN_DEPTH; i++)  in_mem_q[i]  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
      for (int i = 0; i < 24; i++)        w_q[i]       <= '0;
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_cnt_q    <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= '0;
      in_ready_q  <= 1'b0;
      x_q         <= '0;
      out0_prev_q <= 1'b0;
      err_q       <= '0;
    end else begin
      // The core has no reset, so its strobes are ignored until its pipeline has drained.
      case (state_q)
        ST_FLUSH: begin
          if (flush_cnt_q == 2'd0) state_q <= ST_RUN;
          else                     flush_cnt_q <= flush_cnt_q - 2'd1;
        end
        default: ;
      endcase

      if (s_push) begin
        in_mem_q[in_wr_q] <= bus.s_x;
        in_wr_q           <= in_wr_q + 1'b1;
      end
      if (issue) begin
        x_q     <= in_mem_q[in_rd_q];
        in_rd_q <= in_rd_q + 1'b1;
      end
      case ({s_push, issue})
        2'b10:   in_cnt_q <= in_cnt_q + 1'b1;
        2'b01:   in_cnt_q <= in_cnt_q - 1'b1;
        default: ;
      endcase
      in_ready_q <= issue;

      if (w_acc && (bus.w_addr < 5'd24)) w_q[bus.w_addr] <= bus.w_data;

      // out1 is taken with out0: by the trailing strobe it may already show the next result.
      if (cap) begin
        out_mem_q[out_wr_q] <= {out1, out0};
        out_wr_q            <= out_wr_q + 1'b1;
      end
      if (m_pop) out_rd_q <= out_rd_q + 1'b1;
      case ({cap, m_pop})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: ;
      endcase

      case ({issue, cap})
        2'b10:   in_flight_q <= in_flight_q + 3'd1;
        2'b01:   in_flight_q <= in_flight_q - 3'd1;
        default: ;
      endcase

      out0_prev_q <= out0_ready;
      if (run && out0_ready && (in_flight_q == 3'd0)) err_q[0] <= 1'b1;
      if (run && out1_ready && !out0_prev_q)          err_q[1] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mlp_stream_driver.sv
// Bench for mlp_stream_driver: behavioural MLP core model on the core side, scoreboard on the result stream.
module tb_mlp_stream_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mlp_stream_driver_if ifc();

  logic signed [4:0]  x0, x1, x2, x3;
  logic signed [4:0]  w04, w05, w06, w07, w14, w15, w16, w17;
  logic signed [4:0]  w24, w25, w26, w27, w34, w35, w36, w37;
  logic signed [4:0]  w48, w49, w58, w59, w68, w69, w78, w79;
  logic               in_ready;
  logic signed [16:0] out0, out1;
  logic               out0_ready, out1_ready;
  logic [1:0]         err;

  mlp_stream_driver #(.IN_DEPTH(4), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w05(w05), .w06(w06), .w07(w07), .w14(w14), .w15(w15), .w16(w16), .w17(w17),
    .w24(w24), .w25(w25), .w26(w26), .w27(w27), .w34(w34), .w35(w35), .w36(w36), .w37(w37),
    .w48(w48), .w49(w49), .w58(w58), .w59(w59), .w68(w68), .w69(w69), .w78(w78), .w79(w79),
    .in_ready(in_ready), .out0(out0), .out1(out1),
    .out0_ready(out0_ready), .out1_ready(out1_ready), .err(err)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [33:0] exp_q[$];
  int          mw1[4][4];
  int          mw2[4][2];
  int          sink_mode = 1;
  int          n_rx = 0;
  int          n_issue = 0;
  logic [33:0] last_res = '0;
  bit          xmode = 1'b1;
  bit          force_o0 = 1'b0;
  bit          force_o1 = 1'b0;
  bit          pv[1:5];
  logic [33:0] pr[1:5];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference network: hidden layer with ReLU, linear output layer.
  function automatic logic [33:0] mlp(input int xv[4], input int a[4][4], input int b[4][2]);
    int h[4];
    int o[2];
    for (int j = 0; j < 4; j++) begin
      h[j] = 0;
      for (int i = 0; i < 4; i++) h[j] += xv[i] * a[i][j];
      if (h[j] < 0) h[j] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      o[k] = 0;
      for (int j = 0; j < 4; j++) o[k] += b[j][k] * h[j];
    end
    return {o[1][16:0], o[0][16:0]};
  endfunction

  function automatic int wport(input int a);
    case (a)
      0: return int'(w04);   1: return int'(w05);   2: return int'(w06);   3: return int'(w07);
      4: return int'(w14);   5: return int'(w15);   6: return int'(w16);   7: return int'(w17);
      8: return int'(w24);   9: return int'(w25);  10: return int'(w26);  11: return int'(w27);
      12: return int'(w34); 13: return int'(w35);  14: return int'(w36);  15: return int'(w37);
      16: return int'(w48); 17: return int'(w49);  18: return int'(w58);  19: return int'(w59);
      20: return int'(w68); 21: return int'(w69);  22: return int'(w78);  default: return int'(w79);
    endcase
  endfunction

  function automatic int model_w(input int a);
    if (a < 16) return mw1[a / 4][a % 4];
    return mw2[(a - 16) / 2][(a - 16) % 2];
  endfunction

  function automatic void set_model(input int a, input int v);
    if (a < 16)      mw1[a / 4][a % 4] = v;
    else if (a < 24) mw2[(a - 16) / 2][(a - 16) % 2] = v;
  endfunction

  function automatic logic [33:0] core_eval();
    int xv[4];
    int a[4][4];
    int b[4][2];
    xv = '{int'(x0), int'(x1), int'(x2), int'(x3)};
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) a[i][j] = wport(i * 4 + j);
    for (int j = 0; j < 4; j++) for (int k = 0; k < 2; k++) b[j][k] = wport(16 + j * 2 + k);
    return mlp(xv, a, b);
  endfunction

  function automatic logic [33:0] ref_out(input logic [19:0] sx);
    int xv[4];
    for (int i = 0; i < 4; i++) xv[i] = int'($signed(sx[i * 5 +: 5]));
    return mlp(xv, mw1, mw2);
  endfunction

  // Core stand-in: result strobe three cycles after in_ready, trailing strobe one cycle later.
  initial begin
    for (int k = 1; k <= 5; k++) begin pv[k] = 1'b0; pr[k] = '0; end
    out0 = '0; out1 = '0; out0_ready = 1'bx; out1_ready = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 5; k > 1; k--) begin pv[k] = pv[k - 1]; pr[k] = pr[k - 1]; end
      pv[1] = (in_ready === 1'b1);
      pr[1] = core_eval();
      if (in_ready === 1'b1) n_issue++;
      if (pv[4]) begin out0 = pr[4][16:0]; out1 = pr[4][33:17]; end
      out0_ready = xmode ? 1'bx : (pv[4] | force_o0);
      out1_ready = pv[5] | force_o1;
    end
  end

  // Result sink: pops are decided mid-cycle and scored against the expected queue.
  initial begin
    ifc.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (sink_mode)
        0:       ifc.m_ready = 1'b0;
        1:       ifc.m_ready = 1'b1;
        default: ifc.m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rst_n === 1'b1 && ifc.m_valid === 1'b1 && ifc.m_ready) begin
        chk("result_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("result", {ifc.m_out1, ifc.m_out0}, exp_q.pop_front());
        last_res = {ifc.m_out1, ifc.m_out0};
        n_rx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic send(input logic [19:0] x);
    int n = 0;
    ifc.s_valid = 1'b1;
    ifc.s_x = x;
    while (!ifc.s_ready && n < 200) begin @(negedge clk); n++; end
    chk("send_accept", 64'(ifc.s_ready), 1);
    @(posedge clk);
    exp_q.push_back(ref_out(x));
    @(negedge clk);
    ifc.s_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int v, input bit accept);
    ifc.w_we = 1'b1;
    ifc.w_addr = 5'(a);
    ifc.w_data = 5'(v);
    @(posedge clk);
    if (accept) set_model(a, v);
    @(negedge clk);
    ifc.w_we = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || ifc.m_valid || ifc.w_busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 0);
  endtask

  task automatic check_weights(input string tag);
    for (int a = 0; a < 24; a++) chk($sformatf("%s_w%0d", tag, a), 64'(wport(a)), 64'(model_w(a)));
  endtask

  task automatic flush_check(input string tag);
    chk({tag, "_c0"}, 64'(ifc.s_ready), 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, k), 64'(ifc.s_ready), 0);
    end
    @(negedge clk);
    chk({tag, "_run"}, 64'(ifc.s_ready), 1);
  endtask

  task automatic pulse(input bit o0, input bit o1);
    @(posedge clk); #2; force_o0 = o0; force_o1 = o1;
    @(posedge clk); #2; force_o0 = 1'b0; force_o1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int n0;
    int r0;
    rst_n = 1'b0;
    ifc.s_valid = 1'b0; ifc.s_x = '0;
    ifc.w_we = 1'b0; ifc.w_addr = '0; ifc.w_data = '0;
    for (int a = 0; a < 24; a++) set_model(a, 0);

    // Reset with an undriven core strobe, then a flush with both strobes forced high.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(ifc.m_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_s_ready", 64'(ifc.s_ready), 0);
    chk("rst_w_busy", 64'(ifc.w_busy), 1);
    chk("rst_x", 64'({x3, x2, x1, x0}), 0);
    @(posedge clk); #2;
    xmode = 1'b0; force_o0 = 1'b1; force_o1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("flush1_c0", 64'(ifc.s_ready), 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("flush1_c%0d", k), 64'(ifc.s_ready), 0);
    end
    #2; force_o0 = 1'b0; force_o1 = 1'b0;
    @(negedge clk);
    chk("flush1_run", 64'(ifc.s_ready), 1);
    chk("flush1_err", 64'(err), 0);
    chk("flush1_m_valid", 64'(ifc.m_valid), 0);

    // All weights 1, x=(1,2,3,4): each hidden node 10, each output 40, minimum latency.
    for (int a = 0; a < 24; a++) wr(a, 1, 1'b1);
    check_weights("ones");
    sink_mode = 1;
    r0 = n_rx;
    send({5'd4, 5'd3, 5'd2, 5'd1});
    lat = 0;
    while (!ifc.m_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 64'(lat), 5);
    n0 = 0;
    while (n_rx == r0 && n0 < 20) begin @(negedge clk); n0++; end
    chk("ones_count", 64'(n_rx - r0), 1);
    chk("ones_out0", 64'(last_res[16:0]), 40);
    chk("ones_out1", 64'(last_res[33:17]), 40);

    // Negative first layer: ReLU clamps every hidden node to zero.
    for (int a = 0; a < 16; a++) wr(a, -1, 1'b1);
    send({5'd1, 5'd1, 5'd1, 5'd1});
    wait_drain("neg_drain");
    chk("neg_out", 64'(last_res), 0);

    // Backpressure: 8 results held plus 4 queued samples, issue stalls until the sink drains.
    for (int a = 0; a < 24; a++) wr(a, int'($urandom_range(0, 31)) - 16, 1'b1);
    check_weights("rand");
    sink_mode = 0;
    n0 = n_issue;
    r0 = n_rx;
    for (int s = 0; s < 12; s++) send(20'($urandom));
    repeat (10) @(negedge clk);
    chk("bp_s_ready", 64'(ifc.s_ready), 0);
    chk("bp_m_valid", 64'(ifc.m_valid), 1);
    chk("bp_issued", 64'(n_issue - n0), 8);
    chk("bp_popped", 64'(n_rx - r0), 0);
    sink_mode = 1;
    wait_drain("bp_drain");
    chk("bp_total", 64'(n_rx - r0), 12);

    // Weight writes are refused while a sample is in flight and accepted once drained.
    for (int a = 0; a < 24; a++) wr(a, 1, 1'b1);
    send({5'd4, 5'd3, 5'd2, 5'd1});
    @(negedge clk);
    chk("busy_inflight", 64'(ifc.w_busy), 1);
    wr(0, 3, 1'b0);
    chk("busy_w04_kept", 64'(wport(0)), 1);
    wait_drain("busy_drain1");
    send({5'd4, 5'd3, 5'd2, 5'd1});
    wait_drain("busy_drain2");
    chk("busy_old_w", 64'(last_res[16:0]), 40);
    chk("idle_w_busy", 64'(ifc.w_busy), 0);
    wr(0, 3, 1'b1);
    wr(25, 7, 1'b1);
    check_weights("retry");
    send({5'd4, 5'd3, 5'd2, 5'd1});
    wait_drain("retry_drain");
    chk("retry_out0", 64'(last_res[16:0]), 42);

    // Spurious core strobes set sticky error bits and push nothing.
    pulse(1'b1, 1'b0);
    chk("err0", 64'(err), 1);
    chk("err0_m_valid", 64'(ifc.m_valid), 0);
    repeat (2) @(negedge clk);
    pulse(1'b0, 1'b1);
    chk("err1", 64'(err), 3);
    chk("err1_m_valid", 64'(ifc.m_valid), 0);

    // Reset in the middle of traffic clears everything and reruns the flush.
    sink_mode = 0;
    for (int s = 0; s < 3; s++) send(20'($urandom));
    repeat (3) @(negedge clk);
    chk("mid_m_valid_pre", 64'(ifc.m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_m_valid", 64'(ifc.m_valid), 0);
    chk("mid_in_ready", 64'(in_ready), 0);
    chk("mid_s_ready", 64'(ifc.s_ready), 0);
    chk("mid_err", 64'(err), 0);
    chk("mid_x", 64'({x3, x2, x1, x0}), 0);
    chk("mid_w_busy", 64'(ifc.w_busy), 1);
    exp_q.delete();
    for (int a = 0; a < 24; a++) set_model(a, 0);
    check_weights("mid");
    @(negedge clk);
    rst_n = 1'b1;
    flush_check("flush2");
    sink_mode = 1;

    // Random traffic with random sink backpressure.
    for (int a = 0; a < 24; a++) wr(a, int'($urandom_range(0, 31)) - 16, 1'b1);
    check_weights("rand2");
    sink_mode = 2;
    r0 = n_rx;
    for (int s = 0; s < 40; s++) begin
      send(20'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("rand_drain");
    chk("rand_count", 64'(n_rx - r0), 40);
    chk("rand_err", 64'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
